// File: rtl/fetch_queue_unit.sv
// Instruction-fetch unit. It owns the fetch PC, issues requests to a one-cycle-latency
// instruction memory, and queues the returned words with their PCs for decode.
module fetch_queue_unit #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
  parameter int unsigned           DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic                  out_valid,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic [ADDR_WIDTH-1:0] out_pc,
  input  logic                  out_ready
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [ADDR_WIDTH-1:0] fetch_pc_q;
  logic [ADDR_WIDTH-1:0] inflight_pc_q;
  logic                  inflight_q;
  logic [PtrW-1:0]       wr_ptr_q;
  logic [PtrW-1:0]       rd_ptr_q;
  logic [CntW-1:0]       count_q;

  logic [INST_WIDTH-1:0] inst_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];

  logic [CntW:0] used_slots;
  logic          issue;
  logic          enq;
  logic          deq;
  logic          unused_addr_bits;

  // Low address bits of a redirect are forced to zero, so they never reach the PC.
  assign unused_addr_bits = ^redirect_addr[1:0];

  always_comb begin
    used_slots = {1'b0, count_q} + (CntW + 1)'(inflight_q);
    // Credit comes from registered state only; a same-cycle dequeue frees nothing yet.
    issue      = !reset && !redirect_valid && (used_slots < (CntW + 1)'(DEPTH));
    enq        = inflight_q && !reset && !redirect_valid;
    deq        = (count_q != '0) && out_ready;
  end

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q;
  assign out_valid = (count_q != '0);
  assign out_inst  = inst_mem[rd_ptr_q];
  assign out_pc    = pc_mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_ADDR;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else if (redirect_valid) begin
      // Flush everything; the response due next cycle is dropped via inflight_q.
      fetch_pc_q <= {redirect_addr[ADDR_WIDTH-1:2], 2'b00};
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      if (issue) begin
        fetch_pc_q    <= fetch_pc_q + ADDR_WIDTH'(4);
        inflight_pc_q <= fetch_pc_q;
      end
      inflight_q <= issue;
      if (enq) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (deq) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (enq && !deq) begin
        count_q <= count_q + CntW'(1);
      end else if (!enq && deq) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      inst_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]   <= inflight_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit: directed phases push expected PCs, a negedge
// monitor pops them on every accepted output and compares PC and instruction word.
module tb_fetch_queue_unit;

  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] SIG    = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_ready = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int issued = 0;
  int delivered = 0;
  int max_out = 0;
  bit track = 1'b0;
  logic [31:0] exp_q[$];

  fetch_queue_unit #(
    .ADDR_WIDTH(32),
    .INST_WIDTH(32),
    .RESET_ADDR(RST_PC),
    .DEPTH     (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .out_valid     (out_valid),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .out_ready     (out_ready)
  );

  always #5 clk = ~clk;

  // One-cycle-latency memory whose word is a fixed function of the address.
  always @(posedge clk) imem_rdata <= imem_addr ^ SIG;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs just after the edge, return at the following negedge for sampling.
  task automatic step(input logic rst, input logic rdy, input logic rv = 1'b0,
                      input logic [31:0] ra = 32'h0);
    @(posedge clk);
    #1;
    reset          = rst;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_addr  = ra;
    @(negedge clk);
  endtask

  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid === 1'b1 && out_ready) begin
        delivered++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got pc %h expected none at %0t", out_pc, $time);
        end else begin
          e = exp_q.pop_front();
          check("out_pc", out_pc, e);
          check("out_inst", out_inst, e ^ SIG);
        end
      end
      if (!reset && imem_req === 1'b1) issued++;
      if (track && (issued - delivered) > max_out) max_out = issued - delivered;
    end
  end

  initial begin
    // Reset release with decode always ready.
    repeat (3) step(1'b1, 1'b1);
    chk1("reset_imem_req", imem_req, 1'b0);
    chk1("reset_out_valid", out_valid, 1'b0);
    for (int j = 0; j < 8; j++) exp_q.push_back(RST_PC + 32'(4 * j));
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1);
      if (k < 8) begin
        chk1("seq_imem_req", imem_req, 1'b1);
        check("seq_imem_addr", imem_addr, RST_PC + 32'(4 * k));
      end
      if (k < 2) chk1("fill_out_valid", out_valid, 1'b0);
      if (k == 2) chk1("first_out_valid", out_valid, 1'b1);
    end
    step(1'b1, 1'b0);
    check("seq_drained", 32'(exp_q.size()), 32'd0);

    // Decode stalled: exactly DEPTH requests, then drain and resume.
    step(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0);
      chk1("stall_req", imem_req, 1'b1);
      check("stall_addr", imem_addr, RST_PC + 32'(4 * k));
    end
    for (int k = 4; k < 8; k++) begin
      step(1'b0, 1'b0);
      chk1("full_no_req", imem_req, 1'b0);
    end
    chk1("full_out_valid", out_valid, 1'b1);
    for (int j = 0; j < 12; j++) exp_q.push_back(RST_PC + 32'(4 * j));
    step(1'b0, 1'b1);
    chk1("no_same_cycle_credit", imem_req, 1'b0);
    step(1'b0, 1'b1);
    chk1("resume_req", imem_req, 1'b1);
    check("resume_addr", imem_addr, RST_PC + 32'h10);
    repeat (10) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    check("stall_drained", 32'(exp_q.size()), 32'd0);

    // Redirect with 3 queued + 1 in flight, then redirect alongside a dequeue,
    // then reset alongside a redirect.
    step(1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0);
    exp_q.push_back(32'h2000);
    exp_q.push_back(32'h2004);
    exp_q.push_back(32'h2008);
    exp_q.push_back(32'h3000);
    exp_q.push_back(32'h3004);
    step(1'b0, 1'b0, 1'b1, 32'h2002);
    chk1("redir_no_req", imem_req, 1'b0);
    step(1'b0, 1'b1);
    chk1("redir_req", imem_req, 1'b1);
    check("redir_addr", imem_addr, 32'h2000);
    chk1("redir_gap1", out_valid, 1'b0);
    step(1'b0, 1'b1);
    chk1("redir_gap2", out_valid, 1'b0);
    check("redir_addr2", imem_addr, 32'h2004);
    step(1'b0, 1'b1);
    chk1("redir_out_valid", out_valid, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 32'h3000);
    chk1("redir_deq_no_req", imem_req, 1'b0);
    step(1'b0, 1'b1);
    check("redir2_addr", imem_addr, 32'h3000);
    repeat (3) step(1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h4000);
    chk1("rst_redir_no_req", imem_req, 1'b0);
    check("redir_drained", 32'(exp_q.size()), 32'd0);
    step(1'b0, 1'b0);
    chk1("rst_wins_req", imem_req, 1'b1);
    check("rst_wins_addr", imem_addr, RST_PC);

    // PC wraps modulo 2^32.
    step(1'b1, 1'b0);
    for (int j = 0; j < 4; j++) exp_q.push_back(32'hFFFF_FFF8 + 32'(4 * j));
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
    chk1("wrap_no_req", imem_req, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1);
      check("wrap_addr", imem_addr, 32'hFFFF_FFF8 + 32'(4 * k));
    end
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    check("wrap_drained", 32'(exp_q.size()), 32'd0);

    // Random decode backpressure over a long sequential stream.
    step(1'b1, 1'b0);
    for (int j = 0; j < 2100; j++) exp_q.push_back(RST_PC + 32'(4 * j));
    issued    = 0;
    delivered = 0;
    max_out   = 0;
    track     = 1'b1;
    for (int k = 0; k < 2000; k++) step(1'b0, 1'($urandom_range(0, 1)));
    step(1'b1, 1'b0);
    track = 1'b0;
    chk1("outstanding_le_depth", max_out <= int'(DEPTH), 1'b1);
    chk1("random_progress", delivered > 400, 1'b1);
    exp_q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
